// File: rtl/ing_record_fifo_pkg.sv
// Shared defaults and the op-bit clear helper for the ing record FIFO.
// OP_W_MAX bounds the op width the helper can handle.
package ing_record_pkg;

    localparam int          OP_W_DEF        = 32;
    localparam int          PL_W_DEF        = 6;
    localparam int          OP_W_MAX        = 64;
    localparam logic [31:0] OP_CLR_MASK_DEF = 32'h0000_0200;

    function automatic logic [OP_W_MAX-1:0] apply_op_clr(
        input logic [OP_W_MAX-1:0] op,
        input logic [OP_W_MAX-1:0] mask
    );
        return op & ~mask;
    endfunction

endpackage

// File: rtl/ing_record_fifo_if.sv
// Record handshake bundle: producer side (in_*) and consumer side (out_*).
// master = the environment driving records in and accepting them out; slave = the FIFO.
interface ing_record_fifo_if
    import ing_record_pkg::*;
#(
    parameter int OP_W = OP_W_DEF,
    parameter int PL_W = PL_W_DEF
);
    logic            in_vld;
    logic            in_rdy;
    logic [OP_W-1:0] in_op;
    logic [PL_W-1:0] in_pl;
    logic            out_vld;
    logic            out_rdy;
    logic [OP_W-1:0] out_op;
    logic [PL_W-1:0] out_pl;

    modport master (
        output in_vld, in_op, in_pl, out_rdy,
        input  in_rdy, out_vld, out_op, out_pl
    );

    modport slave (
        input  in_vld, in_op, in_pl, out_rdy,
        output in_rdy, out_vld, out_op, out_pl
    );
endinterface

// File: rtl/ing_record_fifo_mem.sv
// DEPTH x W record storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the FIFO occupancy count.
module ing_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 38,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ing_record_fifo.sv
// In-order {op, pl} record FIFO, op masked on write; first-word fall-through, latency 1.
// in_rdy = !full (no pass-through when full); head held while out_vld && !out_rdy. Stats: ING_RECORD_FIFO_STATS_EN.
module ing_record_fifo
    import ing_record_pkg::*;
#(
    parameter int              OP_W        = OP_W_DEF,
    parameter int              PL_W        = PL_W_DEF,
    parameter int              DEPTH       = 8,
    parameter logic [OP_W-1:0] OP_CLR_MASK = OP_W'(OP_CLR_MASK_DEF)
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         flush,
    ing_record_fifo_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
`ifdef ING_RECORD_FIFO_STATS_EN
    ,
    output logic [31:0]                  push_cnt,
    output logic [31:0]                  pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   hi_water
`endif
);
    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [PL_W-1:0] pl;
    } s_ing_t;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [PL_W-1:0] pl;
    } z_ing_t;

    s_ing_t        in_rec;
    z_ing_t        wr_rec;
    z_ing_t        rd_rec;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    assign in_rec.op = bus.in_op;
    assign in_rec.pl = bus.in_pl;
    assign wr_rec.op = OP_W'(apply_op_clr(OP_W_MAX'(in_rec.op), OP_W_MAX'(OP_CLR_MASK)));
    assign wr_rec.pl = in_rec.pl;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign count       = count_q;
    assign bus.in_rdy  = !full;
    assign bus.out_vld = !empty;
    // Gating on empty makes the outputs read zero the instant reset asserts.
    assign bus.out_op  = empty ? '0 : rd_rec.op;
    assign bus.out_pl  = empty ? '0 : rd_rec.pl;

    assign push = bus.in_vld && !full;
    assign pop  = !empty && bus.out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    ing_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (OP_W + PL_W),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata (wr_rec),
        .raddr (rd_ptr_q),
        .rdata (rd_rec)
    );

`ifdef ING_RECORD_FIFO_STATS_EN
    logic [31:0]   push_cnt_q;
    logic [31:0]   pop_cnt_q;
    logic [CW-1:0] hi_water_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            hi_water_q <= '0;
        end else if (flush) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            hi_water_q <= '0;
        end else begin
            if (push && (push_cnt_q != '1)) push_cnt_q <= push_cnt_q + 1'b1;
            if (pop && (pop_cnt_q != '1))   pop_cnt_q  <= pop_cnt_q + 1'b1;
            // Track against next-state so the peak lines up with count.
            if (count_d > hi_water_q)       hi_water_q <= count_d;
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign hi_water = hi_water_q;
`endif
endmodule

// File: tb/tb_ing_record_fifo.sv
// Bench for ing_record_fifo: vector table plus corner sequences, scoreboard on every pop.
module tb_ing_record_fifo;
    localparam int          DEPTH = 8;
    localparam logic [31:0] MASK  = 32'h0000_0200;

    typedef struct packed {
        logic [31:0] op;
        logic [5:0]  pl;
    } rec_t;

    typedef struct {
        logic        vld;
        logic [31:0] op;
        logic [5:0]  pl;
        logic        rdy;
        logic        fl;
        int          cnt;
        logic        ovld;
        logic [31:0] xop;
        logic [5:0]  xpl;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       empty;
`ifdef ING_RECORD_FIFO_STATS_EN
    logic [31:0] push_cnt;
    logic [31:0] pop_cnt;
    logic [3:0]  hi_water;
`endif

    int   total     = 0;
    int   bad       = 0;
    int   pops_seen = 0;
    rec_t sb_q[$];
    rec_t exp_rec;

    ing_record_fifo_if #(.OP_W(32), .PL_W(6)) bus ();

    ing_record_fifo #(
        .OP_W        (32),
        .PL_W        (6),
        .DEPTH       (DEPTH),
        .OP_CLR_MASK (MASK)
    ) dut (
        .clock    (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef ING_RECORD_FIFO_STATS_EN
        ,
        .push_cnt (push_cnt),
        .pop_cnt  (pop_cnt),
        .hi_water (hi_water)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] op, input logic [5:0] pl,
                         input logic r, input logic f);
        bus.in_vld  = v;
        bus.in_op   = op;
        bus.in_pl   = pl;
        bus.out_rdy = r;
        flush       = f;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference occupancy model: samples the settled cycle at the falling edge.
    always @(negedge clk) begin
        logic acc_push;
        logic acc_pop;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            chk("mon_count", count, sb_q.size());
            chk("mon_out_vld", bus.out_vld, sb_q.size() != 0);
            chk("mon_in_rdy", bus.in_rdy, sb_q.size() < DEPTH);
            acc_push = bus.in_vld && (sb_q.size() < DEPTH);
            acc_pop  = bus.out_rdy && (sb_q.size() != 0);
            if (flush) begin
                sb_q.delete();
            end else begin
                if (acc_pop) begin
                    exp_rec = sb_q.pop_front();
                    chk("pop_op", bus.out_op, exp_rec.op);
                    chk("pop_pl", bus.out_pl, exp_rec.pl);
                    pops_seen++;
                end
                if (acc_push) sb_q.push_back('{op: bus.in_op & ~MASK, pl: bus.in_pl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        int   base;
        vt[0] = '{1'b1, 32'hFFFF_FFFF, 6'h2A, 1'b0, 1'b0, 1, 1'b1, 32'hFFFF_FDFF, 6'h2A};
        vt[1] = '{1'b1, 32'h1234_5678, 6'h01, 1'b0, 1'b0, 2, 1'b1, 32'hFFFF_FDFF, 6'h2A};
        vt[2] = '{1'b0, 32'h0000_0000, 6'h00, 1'b1, 1'b0, 1, 1'b1, 32'h1234_5478, 6'h01};
        vt[3] = '{1'b1, 32'h0000_0200, 6'h3F, 1'b1, 1'b0, 1, 1'b1, 32'h0000_0000, 6'h3F};
        vt[4] = '{1'b0, 32'h0000_0000, 6'h00, 1'b1, 1'b0, 0, 1'b0, 32'h0000_0000, 6'h00};
        vt[5] = '{1'b1, 32'hA5A5_A5A5, 6'h15, 1'b1, 1'b0, 1, 1'b1, 32'hA5A5_A5A5, 6'h15};
        vt[6] = '{1'b0, 32'h0000_0000, 6'h00, 1'b0, 1'b1, 0, 1'b0, 32'h0000_0000, 6'h00};

        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_rdy", bus.in_rdy, 1);
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_out_op", bus.out_op, 0);
        chk("rst_out_pl", bus.out_pl, 0);
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vt[i].vld, vt[i].op, vt[i].pl, vt[i].rdy, vt[i].fl);
            cyc();
            chk("vec_count", count, vt[i].cnt);
            chk("vec_out_vld", bus.out_vld, vt[i].ovld);
            chk("vec_full", full, vt[i].cnt == DEPTH);
            chk("vec_empty", empty, vt[i].cnt == 0);
            if (vt[i].ovld) begin
                chk("vec_out_op", bus.out_op, vt[i].xop);
                chk("vec_out_pl", bus.out_pl, vt[i].xpl);
            end
        end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);

        // Fill to capacity, refuse extra pushes, then drain in order.
        base = pops_seen;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, $urandom, 6'(i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_in_rdy", bus.in_rdy, 0);
        chk("fill_count", count, DEPTH);
        drive(1'b1, 32'hDEAD_BEEF, 6'h03, 1'b0, 1'b0);
        cyc();
        chk("ninth_refused", count, DEPTH);
        drive(1'b1, 32'hCAFE_F00D, 6'h04, 1'b1, 1'b0);
        cyc();
        chk("full_push_pop", count, DEPTH - 1);
        drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) cyc();
        chk("drain_empty", empty, 1);
        chk("drain_pops", pops_seen - base, DEPTH);

        // Steady occupancy of 4 with push+pop every cycle, across pointer wrap.
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, 6'(i + 8), 1'b0, 1'b0);
            cyc();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, $urandom, 6'($urandom_range(0, 63)), 1'b1, 1'b0);
            cyc();
            chk("steady_count", count, 4);
        end
        drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        chk("steady_drain_empty", empty, 1);

        // Flush with a concurrent push: that record must vanish.
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0F0F_0000 | i, 6'(i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h1111_1111, 6'h11, 1'b0, 1'b1);
        cyc();
        chk("flush_count", count, 0);
        chk("flush_out_vld", bus.out_vld, 0);
        drive(1'b1, 32'h2222_2222, 6'h22, 1'b0, 1'b0);
        cyc();
        chk("post_flush_op", bus.out_op, 32'h2222_2022);
        chk("post_flush_pl", bus.out_pl, 6'h22);
        chk("post_flush_count", count, 1);
        drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0);
        cyc();
        chk("post_flush_empty", empty, 1);

        // Asynchronous reset mid-stream with 5 stored.
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hFFFF_0000 | i, 6'(i + 1), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("pre_arst_count", count, 5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_vld", bus.out_vld, 0);
        chk("arst_count", count, 0);
        chk("arst_out_op", bus.out_op, 0);
        chk("arst_empty", empty, 1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_arst_count", count, 0);

`ifdef ING_RECORD_FIFO_STATS_EN
        chk("stats_rst_push", push_cnt, 0);
        chk("stats_rst_pop", pop_cnt, 0);
        chk("stats_rst_hi", hi_water, 0);
        for (int i = 0; i < 6; i++) begin drive(1'b1, $urandom, 6'(i), 1'b0, 1'b0); cyc(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0); cyc(); end
        for (int i = 0; i < 4; i++) begin drive(1'b1, $urandom, 6'(i), 1'b0, 1'b0); cyc(); end
        for (int i = 0; i < 3; i++) begin drive(1'b0, 32'h0, 6'h0, 1'b1, 1'b0); cyc(); end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("stats_push", push_cnt, 10);
        chk("stats_pop", pop_cnt, 7);
        chk("stats_hi", hi_water, 6);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("stats_flush_push", push_cnt, 0);
        chk("stats_flush_pop", pop_cnt, 0);
        chk("stats_flush_hi", hi_water, 0);
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ing_record_fifo.md
Name: ing_record_fifo

Overview:
Parametrised buffering stage for {op, pl} records, the next generation of the fixed single-record s_ing/z_ing definition.
- Accepts s_ing-format records over a valid/ready handshake and stores up to DEPTH of them.
- Emits z_ing-format records in order, with a configurable op-bit clear mask applied on write; this generalises the fixed op[9] = 0 patch.
- Sits between an op/payload producer and any downstream consumer that needs elastic buffering.

Parameters:
OP_W, 32, op field width
PL_W, 6, payload field width (former NUM)
DEPTH, 8, record capacity; power of two, >= 2
OP_CLR_MASK, 32'h0000_0200, bits forced to 0 in stored op; width OP_W; default clears bit 9

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all stored records
in_vld  in  1  input record valid
in_op  in  OP_W  input op field
in_pl  in  PL_W  input payload field
in_rdy  out  1  input accept
out_vld  out  1  output record valid
out_op  out  OP_W  output op field (masked)
out_pl  out  PL_W  output payload field
out_rdy  in  1  downstream accept
count  out  $clog2(DEPTH+1)  stored record count
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async assert, sync release): pointers = 0, count = 0, out_vld = 0, out_op = 0, out_pl = 0, empty = 1, full = 0, in_rdy = 1.
- Push: occurs on a clock edge when in_vld && in_rdy.
  - Stored op = in_op & ~OP_CLR_MASK; pl is stored unmodified.
- Pop: occurs when out_vld && out_rdy.
- in_rdy = !full, combinational from registered count.
  - When full, a push is refused even if a pop occurs in the same cycle; no full-cycle pass-through.
- Output is first-word fall-through:
  - A record pushed into an empty FIFO appears on out_vld/out_op/out_pl on the next cycle (latency 1).
  - out_vld = !empty.
  - out_op/out_pl show the head entry and hold stable while out_vld && !out_rdy.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- count is the true occupancy; full and empty are decoded from count, never from pointer equality.
- flush: next cycle pointers = 0, count = 0, out_vld = 0.
  - A push in the flush cycle is discarded; a pop in the flush cycle has no effect.
  - flush has priority over push and pop.
- Reset mid-operation: all stored records are lost and outputs return to reset values immediately (asynchronous).
- in_op/in_pl are X-tolerant when in_vld = 0; nothing is stored.

Optional Feature:
Macro ING_RECORD_FIFO_STATS_EN.
- Defined: adds outputs push_cnt [31:0] and pop_cnt [31:0].
  - Each counts accepted pushes/pops and saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst_n and by flush.
  - Adds output hi_water [$clog2(DEPTH+1)-1:0]: maximum count since reset/flush.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package ing_record_pkg:
  - default localparams OP_W_DEF = 32, PL_W_DEF = 6, OP_CLR_MASK_DEF;
  - function apply_op_clr(op, mask) returning op & ~mask.
- Record typedefs s_ing/z_ing are declared inside the module, because widths depend on module parameters.
- One sub-module: ing_fifo_mem, a DEPTH x (OP_W+PL_W) register array with one write port and an async read port.

Test Plan:
- Reset, then push op=32'hFFFF_FFFF, pl=6'h2A with out_rdy=0 -> next cycle out_vld=1, out_op=32'hFFFF_FDFF, out_pl=6'h2A, count=1.
- Push 8 records with out_rdy=0 -> full=1, in_rdy=0, count=8; a 9th push is not accepted; pop all -> original order, empty=1 after the 8th pop.
- Hold count=4 and drive push and pop every cycle for 20 cycles -> count stays 4, order preserved across pointer wrap.
- With 3 stored, assert flush and in_vld together -> next cycle count=0, out_vld=0, the flush-cycle record is absent.
- Assert rst_n=0 asynchronously mid-stream with count=5 -> out_vld, count and out_op go to 0 before the next clock edge.
- With ING_RECORD_FIFO_STATS_EN: 10 pushes, 7 pops, peak occupancy 6 -> push_cnt=10, pop_cnt=7, hi_water=6; after flush all are 0.
